// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM32 front end: PC source selects, decode modes,
// opcode constants and the data-processing ALU map.
package cpu_pkg;

   localparam logic [1:0] SEL_PC_INC    = 2'b00;
   localparam logic [1:0] SEL_PC_START  = 2'b01;
   localparam logic [1:0] SEL_PC_BRANCH = 2'b10;
   localparam logic [1:0] SEL_PC_ALU    = 2'b11;

   localparam logic [1:0] MODE_DP_IMM     = 2'b00;
   localparam logic [1:0] MODE_DP_REG_IMM = 2'b01;
   localparam logic [1:0] MODE_DP_REG_REG = 2'b11;
   localparam logic [1:0] MODE_MEM_LIT    = 2'b00;
   localparam logic [1:0] MODE_MEM_IMM    = 2'b10;
   localparam logic [1:0] MODE_MEM_REG    = 2'b11;

   localparam logic [3:0] ALU_MOV = 4'b0000;
   localparam logic [3:0] ALU_ADD = 4'b1000;
   localparam logic [3:0] ALU_SUB = 4'b1001;
   localparam logic [3:0] ALU_CMP = 4'b1010;
   localparam logic [3:0] ALU_AND = 4'b1100;
   localparam logic [3:0] ALU_ORR = 4'b1101;

   localparam logic [3:0] SUB_LDR_LIT = 4'b0010;
   localparam logic [3:0] SUB_LDR_IMM = 4'b0100;
   localparam logic [3:0] SUB_LDR_REG = 4'b0110;
   localparam logic [3:0] SUB_STR_IMM = 4'b1100;
   localparam logic [3:0] SUB_STR_REG = 4'b1110;

   localparam logic [6:0] OPC_NONE    = 7'b000_0000;
   localparam logic [6:0] OPC_LDR_LIT = {1'b1, MODE_MEM_LIT, SUB_LDR_LIT};
   localparam logic [6:0] OPC_LDR_IMM = {1'b1, MODE_MEM_IMM, SUB_LDR_IMM};
   localparam logic [6:0] OPC_LDR_REG = {1'b1, MODE_MEM_REG, SUB_LDR_REG};
   localparam logic [6:0] OPC_STR_IMM = {1'b1, MODE_MEM_IMM, SUB_STR_IMM};
   localparam logic [6:0] OPC_STR_REG = {1'b1, MODE_MEM_REG, SUB_STR_REG};

   // Returns {supported, internal alu code} for an ARM data-processing opcode.
   function automatic logic [4:0] alu_map(input logic [3:0] dp_op);
      logic [4:0] r;
      case (dp_op)
         4'b0100: r = {1'b1, ALU_ADD};
         4'b0010: r = {1'b1, ALU_SUB};
         4'b1101: r = {1'b1, ALU_MOV};
         4'b1010: r = {1'b1, ALU_CMP};
         4'b0000: r = {1'b1, ALU_AND};
         4'b1100: r = {1'b1, ALU_ORR};
         default: r = 5'b0_0000;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational IR -> control fields. Optional macro DECODE_ILLEGAL_TRAP_EN adds
// the illegal flag; unsupported encodings always decode to opcode 0.
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [31:0] instr,
   output logic [6:0]  opcode,
   output logic [3:0]  cond,
   output logic        P,
   output logic        U,
   output logic        W,
   output logic [1:0]  shift_op,
   output logic [4:0]  imm5,
   output logic [11:0] imm12,
   output logic [3:0]  rn,
   output logic [3:0]  rd,
   output logic [3:0]  rs,
   output logic [3:0]  rm,
   output logic        en_status_decode
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,output logic       illegal
`endif
);

   logic [4:0] alu_m;
   logic [1:0] mode;
   logic [3:0] sub;
   logic       unsupported;

   assign cond     = instr[31:28];
   assign shift_op = instr[6:5];
   assign imm5     = instr[11:7];
   assign imm12    = instr[11:0];
   assign rn       = instr[19:16];
   assign rd       = instr[15:12];
   assign rs       = instr[11:8];
   assign rm       = instr[3:0];
   assign alu_m    = alu_map(instr[24:21]);

   always_comb begin
      opcode           = OPC_NONE;
      P                = 1'b0;
      U                = 1'b0;
      W                = 1'b0;
      en_status_decode = 1'b0;
      mode             = 2'b00;
      sub              = 4'b0000;
      unsupported      = 1'b1;
      case (instr[27:26])
         2'b00: begin
            en_status_decode = instr[20];
            if (instr[25])     mode = MODE_DP_IMM;
            else if (instr[4]) mode = MODE_DP_REG_REG;
            else               mode = MODE_DP_REG_IMM;
            unsupported = ~alu_m[4];
            if (!unsupported) opcode = {1'b0, mode, alu_m[3:0]};
         end
         2'b01: begin
            P = instr[24];
            U = instr[23];
            W = instr[21];
            // Byte transfers and PC-relative stores have no internal opcode.
            if (!instr[22]) begin
               unsupported = 1'b0;
               if (instr[25]) begin
                  mode = MODE_MEM_REG;
                  sub  = instr[20] ? SUB_LDR_REG : SUB_STR_REG;
               end else if (instr[19:16] != 4'hF) begin
                  mode = MODE_MEM_IMM;
                  sub  = instr[20] ? SUB_LDR_IMM : SUB_STR_IMM;
               end else begin
                  mode        = MODE_MEM_LIT;
                  sub         = SUB_LDR_LIT;
                  unsupported = ~instr[20];
               end
            end
            if (!unsupported) opcode = {1'b1, mode, sub};
         end
         default: unsupported = 1'b1;
      endcase
   end

`ifdef DECODE_ILLEGAL_TRAP_EN
   assign illegal = unsupported;
`endif

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: PC, fetch latency tracking, IR latch and registered decode.
// Optional macro DECODE_ILLEGAL_TRAP_EN adds the registered illegal output.
module instr_fetch_decode
   import cpu_pkg::*;
#(
   parameter int          ADDR_W    = 8,
   parameter logic [31:0] START_PC  = 32'h0000_0000,
   parameter int          FETCH_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_pc,
   input  logic [1:0]        sel_pc,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       alu_result,
   input  logic              load_ir,
   input  logic [31:0]       ram_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [31:0]       pc,
   output logic              instr_ready,
   output logic              dec_valid,
   output logic [6:0]        opcode,
   output logic [3:0]        cond,
   output logic              P,
   output logic              U,
   output logic              W,
   output logic [1:0]        shift_op,
   output logic [4:0]        imm5,
   output logic [11:0]       imm12,
   output logic [3:0]        rn,
   output logic [3:0]        rd,
   output logic [3:0]        rs,
   output logic [3:0]        rm,
   output logic              en_status_decode,
   output logic              fetch_err
`ifdef DECODE_ILLEGAL_TRAP_EN
   ,output logic             illegal
`endif
);

   localparam int             LAT_W   = $clog2(FETCH_LAT + 1);
   localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(FETCH_LAT);

   logic [LAT_W-1:0] lat_cnt;
   logic [31:0]      ir;
   logic [31:0]      pc_next;
   logic             dec_pend;

   logic [6:0]  d_opcode;
   logic [3:0]  d_cond, d_rn, d_rd, d_rs, d_rm;
   logic        d_p, d_u, d_w, d_s;
   logic [1:0]  d_shift;
   logic [4:0]  d_imm5;
   logic [11:0] d_imm12;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        d_illegal;
`endif

   assign ram_addr    = pc[ADDR_W+1:2];
   assign instr_ready = (lat_cnt == LAT_MAX);

   always_comb begin
      pc_next = pc + 32'd4;
      case (sel_pc)
         SEL_PC_START:  pc_next = START_PC;
         SEL_PC_BRANCH: pc_next = branch_target;
         SEL_PC_ALU:    pc_next = alu_result;
         default:       pc_next = pc + 32'd4;
      endcase
   end

   instr_decoder u_dec (
      .instr            (ir),
      .opcode           (d_opcode),
      .cond             (d_cond),
      .P                (d_p),
      .U                (d_u),
      .W                (d_w),
      .shift_op         (d_shift),
      .imm5             (d_imm5),
      .imm12            (d_imm12),
      .rn               (d_rn),
      .rd               (d_rd),
      .rs               (d_rs),
      .rm               (d_rm),
      .en_status_decode (d_s)
`ifdef DECODE_ILLEGAL_TRAP_EN
      ,.illegal         (d_illegal)
`endif
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         pc               <= 32'd0;
         lat_cnt          <= '0;
         ir               <= 32'd0;
         dec_pend         <= 1'b0;
         dec_valid        <= 1'b0;
         fetch_err        <= 1'b0;
         opcode           <= 7'd0;
         cond             <= 4'd0;
         P                <= 1'b0;
         U                <= 1'b0;
         W                <= 1'b0;
         shift_op         <= 2'd0;
         imm5             <= 5'd0;
         imm12            <= 12'd0;
         rn               <= 4'd0;
         rd               <= 4'd0;
         rs               <= 4'd0;
         rm               <= 4'd0;
         en_status_decode <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
         illegal          <= 1'b0;
`endif
      end else begin
         if (load_pc) begin
            pc      <= pc_next;
            lat_cnt <= '0;
         end else if (lat_cnt < LAT_MAX) begin
            lat_cnt <= lat_cnt + LAT_W'(1);
         end
         // An early load_ir still latches whatever the RAM presents.
         if (load_ir) begin
            ir <= ram_rdata;
            if (!instr_ready) fetch_err <= 1'b1;
         end
         dec_pend <= load_ir;
         if (dec_pend) begin
            dec_valid        <= 1'b1;
            opcode           <= d_opcode;
            cond             <= d_cond;
            P                <= d_p;
            U                <= d_u;
            W                <= d_w;
            shift_op         <= d_shift;
            imm5             <= d_imm5;
            imm12            <= d_imm12;
            rn               <= d_rn;
            rd               <= d_rd;
            rs               <= d_rs;
            rm               <= d_rm;
            en_status_decode <= d_s;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal          <= d_illegal;
`endif
         end else if (load_pc || load_ir) begin
            dec_valid <= 1'b0;
`ifdef DECODE_ILLEGAL_TRAP_EN
            illegal   <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: directed test-plan cases plus randomized strobes
// checked against a behavioural reference model of fetch timing and decode.
module tb_instr_fetch_decode;

   localparam logic [31:0] START_PC  = 32'h0000_0000;
   localparam int          FETCH_LAT = 2;

   typedef struct packed {
      logic [6:0]  opcode;
      logic [3:0]  cond;
      logic        p, u, w;
      logic [1:0]  sh;
      logic [4:0]  imm5;
      logic [11:0] imm12;
      logic [3:0]  rn, rd, rs, rm;
      logic        s;
   } dec_t;

   logic        clk = 1'b0;
   logic        rst, load_pc, load_ir;
   logic [1:0]  sel_pc;
   logic [31:0] branch_target, alu_result, ram_rdata;
   logic [7:0]  ram_addr;
   logic [31:0] pc;
   logic        instr_ready, dec_valid, fetch_err;
   logic [6:0]  opcode;
   logic [3:0]  cond, rn, rd, rs, rm;
   logic        P, U, W, en_status_decode;
   logic [1:0]  shift_op;
   logic [4:0]  imm5;
   logic [11:0] imm12;
`ifdef DECODE_ILLEGAL_TRAP_EN
   logic        illegal;
`endif
   dec_t        act;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [31:0] m_pc, m_ir;
   int          m_age;
   logic        m_err, m_dv, m_pend, m_ill;
   dec_t        m_dec;

   always #5 clk = ~clk;

   instr_fetch_decode #(.ADDR_W(8), .START_PC(START_PC), .FETCH_LAT(FETCH_LAT)) dut (
      .clk(clk), .rst(rst), .load_pc(load_pc), .sel_pc(sel_pc),
      .branch_target(branch_target), .alu_result(alu_result),
      .load_ir(load_ir), .ram_rdata(ram_rdata), .ram_addr(ram_addr), .pc(pc),
      .instr_ready(instr_ready), .dec_valid(dec_valid), .opcode(opcode),
      .cond(cond), .P(P), .U(U), .W(W), .shift_op(shift_op), .imm5(imm5),
      .imm12(imm12), .rn(rn), .rd(rd), .rs(rs), .rm(rm),
      .en_status_decode(en_status_decode), .fetch_err(fetch_err)
`ifdef DECODE_ILLEGAL_TRAP_EN
      ,.illegal(illegal)
`endif
   );

   always_comb act = {opcode, cond, P, U, W, shift_op, imm5, imm12, rn, rd, rs, rm,
                      en_status_decode};

   // Decode rules written from the instruction-set view; legal reports support.
   function automatic dec_t ref_decode(input logic [31:0] i, output logic legal);
      dec_t d;
      int   alu, mode;
      d = '0;
      legal = 1'b0;
      d.cond = i[31:28]; d.sh = i[6:5]; d.imm5 = i[11:7]; d.imm12 = i[11:0];
      d.rn = i[19:16]; d.rd = i[15:12]; d.rs = i[11:8]; d.rm = i[3:0];
      if (i[27:26] == 2'b00) begin
         d.s = i[20];
         legal = 1'b1;
         case (i[24:21])
            4'h4: alu = 8;   // ADD
            4'h2: alu = 9;   // SUB
            4'hD: alu = 0;   // MOV
            4'hA: alu = 10;  // CMP
            4'h0: alu = 12;  // AND
            4'hC: alu = 13;  // ORR
            default: begin alu = 0; legal = 1'b0; end
         endcase
         mode = i[25] ? 0 : (i[4] ? 3 : 1);
         if (legal) d.opcode = 7'(mode * 16 + alu);
      end else if (i[27:26] == 2'b01) begin
         d.p = i[24]; d.u = i[23]; d.w = i[21];
         if (!i[22]) begin
            legal = 1'b1;
            if (i[25])                d.opcode = i[20] ? 7'b1110110 : 7'b1111110;
            else if (i[19:16] != 15)  d.opcode = i[20] ? 7'b1100100 : 7'b1101100;
            else if (i[20])           d.opcode = 7'b1000010;
            else                      legal = 1'b0;
         end
      end
      return d;
   endfunction

   // Advance the model by one clock using the inputs currently driven.
   function automatic void model_update();
      logic ready, lg;
      dec_t nd;
      if (rst) begin
         m_pc = 0; m_ir = 0; m_age = 0; m_err = 0; m_dv = 0; m_pend = 0;
         m_dec = '0; m_ill = 0;
         return;
      end
      ready = (m_age >= FETCH_LAT);
      if (m_pend) begin
         nd = ref_decode(m_ir, lg);
         m_dec = nd; m_dv = 1'b1; m_ill = ~lg;
      end else if (load_pc || load_ir) begin
         m_dv = 1'b0; m_ill = 1'b0;
      end
      m_pend = load_ir;
      if (load_ir) begin
         m_ir = ram_rdata;
         if (!ready) m_err = 1'b1;
      end
      if (load_pc) begin
         case (sel_pc)
            2'b00: m_pc = m_pc + 32'd4;
            2'b01: m_pc = START_PC;
            2'b10: m_pc = branch_target;
            default: m_pc = alu_result;
         endcase
         m_age = 0;
      end else if (m_age < 1000) begin
         m_age++;
      end
   endfunction

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
   endtask

   task automatic cycle(input logic lpc, input logic [1:0] sel, input logic [31:0] bt,
                        input logic [31:0] ar, input logic lir, input logic [31:0] rd_v);
      load_pc = lpc; sel_pc = sel; branch_target = bt; alu_result = ar;
      load_ir = lir; ram_rdata = rd_v;
      step();
      load_pc = 1'b0; load_ir = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      load_pc = 1'b1; load_ir = 1'b1; sel_pc = 2'b11; alu_result = 32'h1234_5678;
      ram_rdata = 32'hE080_2001;
      step();
      rst = 1'b0; load_pc = 1'b0; load_ir = 1'b0;
      n_checks++; if (pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", pc); end
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", instr_ready); end
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dec_valid: got %b expected 0", dec_valid); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_err: got %b expected 0", fetch_err); end
      n_checks++; if (act !== '0) begin n_fail++; $display("FAIL reset_fields: got %h expected 0", act); end
   endtask

   task automatic test_start_fetch();
      cycle(1'b1, 2'b01, 0, 0, 1'b0, 0);
      n_checks++; if (pc !== START_PC) begin n_fail++; $display("FAIL start_pc: got %h expected %h", pc, START_PC); end
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready0: got %b expected 0", instr_ready); end
      step();
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL start_ready1: got %b expected 0", instr_ready); end
      step();
      n_checks++; if (instr_ready !== 1'b1) begin n_fail++; $display("FAIL start_ready2: got %b expected 1", instr_ready); end
      n_checks++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL start_addr: got %h expected 00", ram_addr); end
   endtask

   task automatic test_directed_decode();
      logic [31:0] vec [5] = '{32'hE080_2001, 32'hE1A0_10C0, 32'hE041_1312,
                               32'hE49F_0004, 32'hE781_0002};
      logic [6:0]  opc [5] = '{7'b0011000, 7'b0010000, 7'b0111001, 7'b1000010, 7'b1111110};
      dec_t exp_d;
      logic lg;
      for (int k = 0; k < 5; k++) begin
         cycle(1'b0, 2'b00, 0, 0, 1'b1, vec[k]);
         n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL dir_latency[%0d]: got %b expected 0", k, dec_valid); end
         step();
         exp_d = ref_decode(vec[k], lg);
         n_checks++; if (dec_valid !== 1'b1) begin n_fail++; $display("FAIL dir_valid[%0d]: got %b expected 1", k, dec_valid); end
         n_checks++; if (opcode !== opc[k]) begin n_fail++; $display("FAIL dir_opcode[%0d]: got %b expected %b", k, opcode, opc[k]); end
         n_checks++; if (act !== exp_d) begin n_fail++; $display("FAIL dir_fields[%0d]: got %h expected %h", k, act, exp_d); end
      end
      // the STR register case: P=1 U=1 rn=1 rm=2
      n_checks++; if ({P, U, rn, rm} !== {1'b1, 1'b1, 4'd1, 4'd2}) begin
         n_fail++; $display("FAIL dir_str_fields: got %h expected %h", {P, U, rn, rm}, {1'b1, 1'b1, 4'd1, 4'd2});
      end
      step(); step();
      n_checks++; if (dec_valid !== 1'b1 || opcode !== 7'b1111110) begin
         n_fail++; $display("FAIL dir_hold: got %b/%b expected 1/1111110", dec_valid, opcode);
      end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL dir_no_err: got %b expected 0", fetch_err); end
   endtask

   task automatic test_pc_step();
      cycle(1'b1, 2'b11, 0, 32'h0000_0FFC, 1'b0, 0);
      n_checks++; if (dec_valid !== 1'b0) begin n_fail++; $display("FAIL pc_load_clears_valid: got %b expected 0", dec_valid); end
      cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
      n_checks++; if (pc !== 32'h0000_1000) begin n_fail++; $display("FAIL pc_inc: got %h expected 00001000", pc); end
      n_checks++; if (ram_addr !== 8'h00) begin n_fail++; $display("FAIL pc_inc_addr: got %h expected 00", ram_addr); end
      cycle(1'b1, 2'b11, 0, 32'hFFFF_FFFC, 1'b0, 0);
      cycle(1'b1, 2'b00, 0, 0, 1'b0, 0);
      n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL pc_wrap: got %h expected 00000000", pc); end
   endtask

   task automatic test_branch();
      cycle(1'b1, 2'b10, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 0);
      n_checks++; if (pc !== 32'h40) begin n_fail++; $display("FAIL branch_pc: got %h expected 00000040", pc); end
      n_checks++; if (ram_addr !== 8'h10) begin n_fail++; $display("FAIL branch_addr: got %h expected 10", ram_addr); end
      n_checks++; if (instr_ready !== 1'b0) begin n_fail++; $display("FAIL branch_ready: got %b expected 0", instr_ready); end
   endtask

   task automatic test_fetch_err();
      cycle(1'b1, 2'b01, 0, 0, 1'b0, 0);
      cycle(1'b0, 2'b00, 0, 0, 1'b1, 32'hE080_2001);
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", fetch_err); end
      step(); step(); step();
      cycle(1'b0, 2'b00, 0, 0, 1'b1, 32'hE1A0_10C0);
      step();
      n_checks++; if (fetch_err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b expected 1", fetch_err); end
      n_checks++; if (opcode !== 7'b0010000) begin n_fail++; $display("FAIL err_late_decode: got %b expected 0010000", opcode); end
   endtask

   task automatic test_reset_mid_fetch();
      cycle(1'b1, 2'b10, 32'h0000_0080, 0, 1'b0, 0);
      step();
      rst = 1'b1; load_ir = 1'b1; ram_rdata = 32'hE049_F004;
      step();
      rst = 1'b0; load_ir = 1'b0;
      n_checks++; if (pc !== 32'd0 || ram_addr !== 8'd0) begin n_fail++; $display("FAIL midrst_pc: got %h expected 0", pc); end
      n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL midrst_err: got %b expected 0", fetch_err); end
      n_checks++; if (dec_valid !== 1'b0 || instr_ready !== 1'b0) begin
         n_fail++; $display("FAIL midrst_flags: got %b%b expected 00", dec_valid, instr_ready);
      end
      step();
      n_checks++; if (act !== '0 || dec_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_fields: got %h expected 0", act); end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      logic [3:0]  dp_ops [6] = '{4'h4, 4'h2, 4'hD, 4'hA, 4'h0, 4'hC};
      r = $urandom;
      case ($urandom_range(0, 3))
         0: begin
            r[27:26] = 2'b00;
            if ($urandom_range(0, 3) != 0) r[24:21] = dp_ops[$urandom_range(0, 5)];
         end
         1: begin
            r[27:26] = 2'b01;
            r[22] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0) r[19:16] = 4'hF;
         end
         2: r[27] = 1'b1;
         default: ;
      endcase
      return r;
   endfunction

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst           = ($urandom_range(0, 60) == 0);
         load_pc       = ($urandom_range(0, 5) == 0);
         sel_pc        = 2'($urandom_range(0, 3));
         branch_target = $urandom;
         alu_result    = $urandom;
         load_ir       = ($urandom_range(0, 3) == 0);
         ram_rdata     = rand_instr();
         step();
         n_checks++; if (pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc[%0d]: got %h expected %h", c, pc, m_pc); end
         n_checks++; if (ram_addr !== m_pc[9:2]) begin n_fail++; $display("FAIL rnd_addr[%0d]: got %h expected %h", c, ram_addr, m_pc[9:2]); end
         n_checks++; if (instr_ready !== (m_age >= FETCH_LAT)) begin
            n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", c, instr_ready, (m_age >= FETCH_LAT));
         end
         n_checks++; if (fetch_err !== m_err) begin n_fail++; $display("FAIL rnd_err[%0d]: got %b expected %b", c, fetch_err, m_err); end
         n_checks++; if (dec_valid !== m_dv) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, dec_valid, m_dv); end
         if (m_dv) begin
            n_checks++; if (act !== m_dec) begin n_fail++; $display("FAIL rnd_fields[%0d]: got %h expected %h", c, act, m_dec); end
`ifdef DECODE_ILLEGAL_TRAP_EN
            n_checks++; if (illegal !== m_ill) begin n_fail++; $display("FAIL rnd_illegal[%0d]: got %b expected %b", c, illegal, m_ill); end
`endif
         end
      end
      rst = 1'b0; load_pc = 1'b0; load_ir = 1'b0;
   endtask

   initial begin
      rst = 1'b1; load_pc = 1'b0; load_ir = 1'b0; sel_pc = 2'b00;
      branch_target = 0; alu_result = 0; ram_rdata = 0;
      m_pc = 0; m_ir = 0; m_age = 0; m_err = 0; m_dv = 0; m_pend = 0; m_dec = '0; m_ill = 0;
      @(posedge clk); #1;
      test_reset();
      test_start_fetch();
      test_directed_decode();
      test_pc_step();
      test_branch();
      test_fetch_err();
      test_reset_mid_fetch();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_fetch_decode.md
Name: instr_fetch_decode

Overview:
- Front end of the multi-cycle ARM32 core. It owns the PC and IR, issues instruction-RAM reads and tracks their read latency.
- It decodes the latched instruction into the fields the main controller consumes: opcode, cond, P/U/W, shift_op, en_status_decode and register indices.
- It sits directly upstream of the controller and acts on the controller's load_pc, sel_pc and load_ir strobes.

Parameters:
- ADDR_W, 8, instruction RAM word-address width.
- START_PC, 32'h0000_0000, byte address loaded when sel_pc=01.
- FETCH_LAT, 2, cycles from PC change until ram_rdata is valid (registered address plus registered data).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- load_pc  in  1  controller strobe: update PC this edge.
- sel_pc  in  2  PC source: 00 pc+4, 01 START_PC, 10 branch_target, 11 alu_result.
- branch_target  in  32  branch destination (byte address).
- alu_result  in  32  ALU C-register value, used for writes to PC.
- load_ir  in  1  controller strobe: latch ram_rdata into IR.
- ram_rdata  in  32  instruction RAM read data.
- ram_addr  out  ADDR_W  word address, equal to pc[ADDR_W+1:2].
- pc  out  32  current PC.
- instr_ready  out  1  ram_rdata is valid for the current PC.
- dec_valid  out  1  decoded fields are valid.
- opcode  out  7  internal opcode (encoding below).
- cond  out  4  instr[31:28].
- P, U, W  out  1 each  instr[24], instr[23], instr[21]; all 0 for non-memory instructions.
- shift_op  out  2  instr[6:5].
- imm5  out  5  instr[11:7].
- imm12  out  12  instr[11:0].
- rn, rd, rs, rm  out  4 each  instr[19:16], instr[15:12], instr[11:8], instr[3:0].
- en_status_decode  out  1  S bit (instr[20]) of a data-processing instruction, else 0.
- fetch_err  out  1  sticky: load_ir was asserted while instr_ready=0.

Behaviour:
- Reset, on the clock edge with rst=1:
  - pc=0, IR=0, lat_cnt=0.
  - instr_ready, dec_valid and fetch_err = 0.
  - All decoded outputs = 0.
  - Reset overrides load_pc and load_ir in the same cycle.
- PC update:
  - On load_pc, pc takes the value selected by sel_pc. The pc+4 addition wraps modulo 2^32.
  - Loading the PC clears lat_cnt, instr_ready and dec_valid.
- Fetch latency:
  - lat_cnt increments each cycle while lat_cnt < FETCH_LAT.
  - instr_ready = (lat_cnt == FETCH_LAT).
  - Net effect: after load_pc in cycle N, instr_ready is 1 from cycle N+FETCH_LAT.
- Instruction latch:
  - On load_ir with instr_ready=1, IR <= ram_rdata. In the following cycle the decoded outputs are registered from IR and dec_valid=1.
  - Decode latency is therefore exactly 1 cycle after the IR latch.
- Error and hold:
  - load_ir with instr_ready=0 still latches ram_rdata and sets fetch_err. fetch_err clears only on rst.
  - Decoded outputs and dec_valid hold until the next load_pc or load_ir.
  - If load_pc and load_ir are asserted in the same cycle, both take effect: IR latches the old-address data, and the PC/latency state restarts.
- opcode encoding for data-processing instructions (instr[27:26]=00): {0, mode, alu}.
  - mode 00 = immediate (instr[25]=1).
  - mode 01 = register with immediate shift (instr[25]=0, instr[4]=0).
  - mode 11 = register-shifted register (instr[25]=0, instr[4]=1).
  - alu is mapped from instr[24:21] through a package table: ADD→1000, SUB→1001, MOV→0000, CMP→1010, AND→1100, ORR→1101.
- opcode encoding for memory instructions (instr[27:26]=01): {1, mode, sub}.
  - mode 00 = literal (I=0 and Rn=15).
  - mode 10 = immediate (I=0, Rn≠15).
  - mode 11 = register (I=1).
  - sub comes from package constants: LDR literal 0010, LDR immediate 0100, LDR register 0110, STR immediate 1100, STR register 1110.
- Any other encoding produces opcode 7'b0000000.

Optional Feature:
- Macro: DECODE_ILLEGAL_TRAP_EN.
- Defined: an extra output illegal (1 bit) is asserted together with dec_valid for any unsupported encoding, and opcode is forced to 0. This covers unmapped alu values, instr[27:26]=1x, and B=1 on memory instructions.
- Undefined: no illegal port; unsupported encodings silently decode to opcode 0.

Decomposition:
- Shared package cpu_pkg holds:
  - OPC_* constants (full 7-bit opcodes).
  - MODE_* constants.
  - The ALU map function.
  - SEL_PC_* localparams.
- Sub-module instr_decoder: purely combinational IR→fields. The top-level module holds the PC, the latency counter, the IR and the decode output registers.

Test Plan:
- Reset, then load_pc with sel_pc=01 → pc=START_PC and instr_ready=0. Two cycles later instr_ready=1, with ram_addr=0.
- ram_rdata=E0802001 (ADD r2,r0,r1), load_ir → next cycle dec_valid=1, opcode=0011000, cond=1110, rn=0, rd=2, rm=1, en_status_decode=0.
- E1A010C0 (MOV r1,r0,ASR #1) → opcode=0010000, shift_op=10, imm5=1, rd=1, rm=0. E0411312 (SUB r1,r1,r2,LSL r3) → opcode=0111001, rs=3, rm=2.
- E49F0004 (post-indexed LDR r0,[pc],#4) → opcode=1000010, P=0, U=1, W=0, imm12=4. E7810002 (STR r0,[r1,r2]) → opcode=1111110, P=1, U=1, rn=1, rm=2.
- Address stepping and error path:
  - sel_pc=00 from pc=0x00000FFC → pc=0x00001000.
  - sel_pc=10 with branch_target=0x40 → ram_addr=0x10.
  - Asserting load_ir 1 cycle after load_pc → fetch_err=1, and it stays 1 until rst.
- Reset asserted mid-fetch (lat_cnt=1) together with load_ir → all outputs 0 and fetch_err=0 on the next cycle.
